// File: rtl/cache_struct_pkg.sv
// Shared cache types: MESI states, trace request op codes, buffered request entry
// and field widths (overridable through TAG_BITS / NUM_OF_SETS_BITS / BYTE_OFFSET_BITS / COUNTER_BITS).
`ifndef TAG_BITS
`define TAG_BITS 12
`endif
`ifndef NUM_OF_SETS_BITS
`define NUM_OF_SETS_BITS 14
`endif
`ifndef BYTE_OFFSET_BITS
`define BYTE_OFFSET_BITS 6
`endif
`ifndef COUNTER_BITS
`define COUNTER_BITS 8
`endif

package cache_struct_pkg;

  localparam int TAG_BITS         = `TAG_BITS;
  localparam int NUM_OF_SETS_BITS = `NUM_OF_SETS_BITS;
  localparam int BYTE_OFFSET_BITS = `BYTE_OFFSET_BITS;
  localparam int COUNTER_BITS     = `COUNTER_BITS;

  typedef enum logic [1:0] {
    INVALID   = 2'd0,
    SHARED    = 2'd1,
    EXCLUSIVE = 2'd2,
    MODIFIED  = 2'd3
  } mesi_states_e;

  typedef enum logic [3:0] {
    RD_L1D   = 4'd0,
    WR_L1D   = 4'd1,
    RD_L1I   = 4'd2,
    SNP_RD   = 4'd3,
    SNP_WR   = 4'd4,
    SNP_RWIM = 4'd5,
    SNP_INV  = 4'd6,
    CLR_RST  = 4'd8,
    PRINT    = 4'd9
  } req_op_e;

  typedef struct packed {
    req_op_e                     op;
    logic [TAG_BITS-1:0]         tag;
    logic [NUM_OF_SETS_BITS-1:0] index;
    logic [BYTE_OFFSET_BITS-1:0] offset;
  } req_entry_st;

  // Codes 7 and 10-15 have no request meaning.
  function automatic logic is_legal_cmd(input logic [3:0] cmd);
    return (cmd <= 4'd6) || (cmd == 4'd8) || (cmd == 4'd9);
  endfunction

endpackage

// File: rtl/llc_req_fifo.sv
// Request buffer: circular FIFO with a registered head entry that holds its
// last value while empty and updates one cycle after a push into an empty buffer.
module llc_req_fifo #(
  parameter int  DEPTH   = 4,
  parameter type entry_t = logic
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  entry_t wr_data,
  input  logic   pop,
  output entry_t head,
  output logic   full,
  output logic   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  entry_t             mem [DEPTH];
  entry_t             head_reg;
  logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               push_ok, pop_ok;

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = head_reg;

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push_ok && !pop_ok) count_next = count_reg + CNT_W'(1);
    if (!push_ok && pop_ok) count_next = count_reg - CNT_W'(1);
    if (pop_ok) rd_ptr_next = rd_ptr_reg + PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      // The incoming entry becomes head when it lands on the next read slot.
      if (count_next != '0) begin
        if (push_ok && (wr_ptr_reg == rd_ptr_next)) head_reg <= wr_data;
        else                                       head_reg <= mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: rtl/llc_req_decoder.sv
// Trace command decoder: splits addresses, buffers decoded requests in order and
// flags illegal codes. Read/write statistics are built only with LLC_REQ_STATS_EN.
module llc_req_decoder
  import cache_struct_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_BITS  = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [3:0]                   in_cmd,
  input  logic [ADDR_BITS-1:0]         in_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   out_op,
  output logic [`TAG_BITS-1:0]         out_tag,
  output logic [`NUM_OF_SETS_BITS-1:0] out_index,
  output logic [`BYTE_OFFSET_BITS-1:0] out_offset,
  output logic                         illegal_cmd,
  output logic [`COUNTER_BITS-1:0]     read_cnt,
  output logic [`COUNTER_BITS-1:0]     write_cnt
);

  localparam int IDX_LSB = BYTE_OFFSET_BITS;
  localparam int TAG_LSB = BYTE_OFFSET_BITS + NUM_OF_SETS_BITS;

  req_entry_st enq_entry, head;
  logic        fifo_full, fifo_empty;
  logic        accept, push, pop;
  logic        illegal_cmd_reg;

  assign in_ready  = !fifo_full;
  assign out_valid = !fifo_empty;
  assign accept    = in_valid && in_ready;
  assign push      = accept && is_legal_cmd(in_cmd);
  assign pop       = out_valid && out_ready;

  always_comb begin
    enq_entry        = '0;
    enq_entry.op     = req_op_e'(in_cmd);
    enq_entry.offset = in_addr[BYTE_OFFSET_BITS-1:0];
    enq_entry.index  = in_addr[IDX_LSB +: NUM_OF_SETS_BITS];
    enq_entry.tag    = in_addr[TAG_LSB +: TAG_BITS];
  end

  llc_req_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (req_entry_st)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (enq_entry),
    .pop     (pop),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_op     = head.op;
  assign out_tag    = head.tag;
  assign out_index  = head.index;
  assign out_offset = head.offset;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_cmd_reg <= 1'b0;
    else        illegal_cmd_reg <= accept && !is_legal_cmd(in_cmd);
  end
  assign illegal_cmd = illegal_cmd_reg;

`ifdef LLC_REQ_STATS_EN
  localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;
  logic [COUNTER_BITS-1:0] read_cnt_reg, write_cnt_reg;

  // Counters saturate; CLR_RST clears both when it leaves the buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      read_cnt_reg  <= '0;
      write_cnt_reg <= '0;
    end else if (pop) begin
      if (head.op == CLR_RST) begin
        read_cnt_reg  <= '0;
        write_cnt_reg <= '0;
      end else if ((head.op == RD_L1D) || (head.op == RD_L1I)) begin
        if (read_cnt_reg != CNT_MAX) read_cnt_reg <= read_cnt_reg + COUNTER_BITS'(1);
      end else if (head.op == WR_L1D) begin
        if (write_cnt_reg != CNT_MAX) write_cnt_reg <= write_cnt_reg + COUNTER_BITS'(1);
      end
    end
  end
  assign read_cnt  = read_cnt_reg;
  assign write_cnt = write_cnt_reg;
`else
  assign read_cnt  = '0;
  assign write_cnt = '0;
`endif

endmodule

// File: tb/tb_llc_req_decoder.sv
// Directed bench for llc_req_decoder; counter expectations follow LLC_REQ_STATS_EN.
module tb_llc_req_decoder;
  import cache_struct_pkg::*;

`ifdef LLC_REQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int CNT_ALL_ONES = (1 << COUNTER_BITS) - 1;

  logic                        clk, rst_n;
  logic                        in_valid, in_ready, out_valid, out_ready, illegal_cmd;
  logic [3:0]                  in_cmd, out_op;
  logic [31:0]                 in_addr;
  logic [TAG_BITS-1:0]         out_tag;
  logic [NUM_OF_SETS_BITS-1:0] out_index;
  logic [BYTE_OFFSET_BITS-1:0] out_offset;
  logic [COUNTER_BITS-1:0]     read_cnt, write_cnt;

  int n_checks = 0;
  int n_errs   = 0;

  llc_req_decoder #(.FIFO_DEPTH(4), .ADDR_BITS(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_addr(in_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_tag(out_tag), .out_index(out_index), .out_offset(out_offset),
    .illegal_cmd(illegal_cmd), .read_cnt(read_cnt), .write_cnt(write_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ec(input int v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] seq [4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_cmd = '0; in_addr = '0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_illegal", 32'(illegal_cmd), 0);
    chk("rst_out_op", 32'(out_op), 0);
    chk("rst_read_cnt", 32'(read_cnt), 0);
    chk("rst_write_cnt", 32'(write_cnt), 0);
    #10 rst_n = 1'b1;

    // Single read: decode and next-cycle latency
    out_ready = 1'b1; in_valid = 1'b1; in_cmd = 4'd0; in_addr = 32'h1234_5678;
    tick();
    in_valid = 1'b0;
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_op", 32'(out_op), 0);
    chk("single_tag", 32'(out_tag), 32'h123);
    chk("single_index", 32'(out_index), 32'h1159);
    chk("single_offset", 32'(out_offset), 32'h38);
    tick();
    $display("txn single read dequeued: read_cnt=%0d", read_cnt);
    chk("single_empty", 32'(out_valid), 0);
    chk("single_read_cnt", 32'(read_cnt), ec(1));
    chk("single_tag_held", 32'(out_tag), 32'h123);

    // Fill to full with out_ready low, then drain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_cmd = 4'(i + 1); in_addr = 32'(i) << 6;
      chk("fill_ready", 32'(in_ready), 1);
      tick();
      $display("txn push cmd=%0d", i + 1);
    end
    in_cmd = 4'd5; in_addr = 32'h0000_0040;
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_head", 32'(out_op), 1);
    tick();
    chk("full_hold_ready", 32'(in_ready), 0);
    chk("full_head_stable", 32'(out_op), 1);
    out_ready = 1'b1;
    tick();
    chk("drain1_op", 32'(out_op), 2);
    chk("drain1_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    chk("drain2_op", 32'(out_op), 3);
    tick();
    chk("drain3_op", 32'(out_op), 4);
    tick();
    chk("drain4_op", 32'(out_op), 5);
    chk("drain4_index", 32'(out_index), 1);
    tick();
    $display("txn drain done: read_cnt=%0d write_cnt=%0d", read_cnt, write_cnt);
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_read_cnt", 32'(read_cnt), ec(2));
    chk("drain_write_cnt", 32'(write_cnt), ec(1));

    // Illegal codes
    in_valid = 1'b1; in_cmd = 4'd7;
    tick();
    chk("ill7_pulse", 32'(illegal_cmd), 1);
    chk("ill7_no_out", 32'(out_valid), 0);
    in_cmd = 4'd12;
    tick();
    in_valid = 1'b0;
    chk("ill12_pulse", 32'(illegal_cmd), 1);
    chk("ill12_no_out", 32'(out_valid), 0);
    tick();
    $display("txn illegal codes 7,12 done");
    chk("ill_pulse_end", 32'(illegal_cmd), 0);
    chk("ill_no_out", 32'(out_valid), 0);
    chk("ill_read_cnt", 32'(read_cnt), ec(2));
    chk("ill_write_cnt", 32'(write_cnt), ec(1));

    // Reset with 3 buffered entries
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_cmd = 4'(i); in_addr = 32'hFFF0_0000;
      tick();
    end
    in_valid = 1'b0;
    chk("prerst_valid", 32'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    $display("txn mid-operation reset asserted");
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_ready", 32'(in_ready), 1);
    chk("midrst_tag", 32'(out_tag), 0);
    chk("midrst_read_cnt", 32'(read_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    chk("postrst_valid1", 32'(out_valid), 0);
    tick();
    chk("postrst_valid2", 32'(out_valid), 0);

    // WR, RD, CLR_RST, RD ordering and clear
    out_ready = 1'b0;
    seq[0] = 4'd1; seq[1] = 4'd0; seq[2] = 4'd8; seq[3] = 4'd2;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_cmd = seq[i]; in_addr = 32'h0;
      tick();
    end
    in_valid = 1'b0;
    chk("clr_head", 32'(out_op), 1);
    out_ready = 1'b1;
    tick();
    chk("clr_seq1_op", 32'(out_op), 0);
    chk("clr_seq1_wr", 32'(write_cnt), ec(1));
    tick();
    chk("clr_seq2_op", 32'(out_op), 8);
    chk("clr_pre_rd", 32'(read_cnt), ec(1));
    chk("clr_pre_wr", 32'(write_cnt), ec(1));
    tick();
    chk("clr_seq3_op", 32'(out_op), 2);
    chk("clr_post_rd", 32'(read_cnt), 0);
    chk("clr_post_wr", 32'(write_cnt), 0);
    tick();
    $display("txn clr sequence done: read_cnt=%0d write_cnt=%0d", read_cnt, write_cnt);
    chk("clr_end_empty", 32'(out_valid), 0);
    chk("clr_end_rd", 32'(read_cnt), ec(1));
    chk("clr_end_wr", 32'(write_cnt), 0);

    // Saturation: stream more reads than the counter range
    in_valid = 1'b1; in_cmd = 4'd0; out_ready = 1'b1;
    repeat (300) tick();
    in_valid = 1'b0;
    tick();
    tick();
    $display("txn saturation stream done: read_cnt=%0d", read_cnt);
    chk("sat_read_cnt", 32'(read_cnt), ec(CNT_ALL_ONES));
    chk("sat_write_cnt", 32'(write_cnt), 0);
    chk("sat_empty", 32'(out_valid), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
